// File: rtl/float_point_issue_unit_pkg.sv
// Shared field layouts, encodings and FSM states for the floating-point issue unit.
// Operand fields are carried as a 64-bit struct laid out exactly like a double word.
package float_point_issue_unit_pkg;

  localparam int DP_EXP_W    = 11;
  localparam int DP_FRAC_W   = 52;
  localparam int WORD_W      = 1 + DP_EXP_W + DP_FRAC_W;
  localparam int DP_SIGN_POS = 63;
  localparam int DP_EXP_LSB  = 52;

  localparam int SP_EXP_W    = 8;
  localparam int SP_FRAC_W   = 23;
  localparam int SP_SIGN_POS = 31;
  localparam int SP_EXP_LSB  = 23;

  localparam logic MODE_ADD    = 1'b0;
  localparam logic MODE_SUB    = 1'b1;
  localparam logic PREC_DOUBLE = 1'b0;
  localparam logic PREC_SINGLE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ISSUE       = 2'd1,
    ST_WAIT_RESULT = 2'd2,
    ST_RESPOND     = 2'd3
  } state_e;

  typedef struct packed {
    logic                 sign;
    logic [DP_EXP_W-1:0]  exponent;
    logic [DP_FRAC_W-1:0] fraction;
  } fp_fields_t;

endpackage

// File: rtl/float_point_pack_unpack.sv
// Combinational converter between a packed IEEE word and {sign, exponent, fraction}.
// PACK=0 unpacks data_i (word) into data_o (fp_fields_t); PACK=1 does the reverse.
module float_point_pack_unpack
  import float_point_issue_unit_pkg::*;
#(
  parameter bit PACK = 1'b0
) (
  input  logic              precision_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o
);

  fp_fields_t fields;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    fields = '0;
    data_o = '0;
    if (PACK) begin
      fields = fp_fields_t'(data_i);
      if (precision_i == PREC_SINGLE) begin
        // Upper exponent/fraction bits are dropped; bits [63:32] stay zero.
        data_o[SP_SIGN_POS]              = fields.sign;
        data_o[SP_EXP_LSB +: SP_EXP_W]   = fields.exponent[SP_EXP_W-1:0];
        data_o[SP_FRAC_W-1:0]            = fields.fraction[SP_FRAC_W-1:0];
      end else begin
        data_o[DP_SIGN_POS]              = fields.sign;
        data_o[DP_EXP_LSB +: DP_EXP_W]   = fields.exponent;
        data_o[DP_FRAC_W-1:0]            = fields.fraction;
      end
    end else begin
      if (precision_i == PREC_SINGLE) begin
        fields.sign     = data_i[SP_SIGN_POS];
        fields.exponent = DP_EXP_W'(data_i[SP_EXP_LSB +: SP_EXP_W]);
        fields.fraction = DP_FRAC_W'(data_i[SP_FRAC_W-1:0]);
      end else begin
        fields.sign     = data_i[DP_SIGN_POS];
        fields.exponent = data_i[DP_EXP_LSB +: DP_EXP_W];
        fields.fraction = data_i[DP_FRAC_W-1:0];
      end
      data_o = fields;
    end
  end

endmodule

// File: rtl/float_point_issue_unit.sv
// Requester-side partner of the floating-point adder: unpacks an operand pair, issues it,
// collects the result under a watchdog and returns the repacked word with its tag.
module float_point_issue_unit
  import float_point_issue_unit_pkg::*;
#(
  parameter int EXPONENT_WIDTH_IN_BITS = DP_EXP_W,
  parameter int FRACTION_WIDTH_IN_BITS = DP_FRAC_W,
  parameter int WORD_WIDTH_IN_BITS     = 1 + EXPONENT_WIDTH_IN_BITS + FRACTION_WIDTH_IN_BITS,
  parameter int TAG_WIDTH_IN_BITS      = 4,
  parameter int TIMEOUT_CYCLES         = 64
) (
  input  logic                              clk_in,
  input  logic                              reset_in,
  input  logic                              request_valid_in,
  output logic                              request_ready_out,
  input  logic                              request_mode_in,
  input  logic                              request_precision_in,
  input  logic [WORD_WIDTH_IN_BITS-1:0]     request_operand_0_in,
  input  logic [WORD_WIDTH_IN_BITS-1:0]     request_operand_1_in,
  input  logic [TAG_WIDTH_IN_BITS-1:0]      request_tag_in,
  output logic                              adder_operantion_mode_out,
  output logic                              adder_precision_out,
  output logic                              adder_operand_0_valid_out,
  output logic                              adder_operand_1_valid_out,
  output logic                              adder_operand_0_sign_out,
  output logic [EXPONENT_WIDTH_IN_BITS-1:0] adder_operand_0_exponent_out,
  output logic [FRACTION_WIDTH_IN_BITS-1:0] adder_operand_0_fraction_out,
  output logic                              adder_operand_1_sign_out,
  output logic [EXPONENT_WIDTH_IN_BITS-1:0] adder_operand_1_exponent_out,
  output logic [FRACTION_WIDTH_IN_BITS-1:0] adder_operand_1_fraction_out,
  input  logic                              adder_issue_ack_in,
  input  logic                              adder_product_valid_in,
  input  logic                              adder_product_sign_in,
  input  logic [EXPONENT_WIDTH_IN_BITS-1:0] adder_product_exponent_in,
  input  logic [FRACTION_WIDTH_IN_BITS-1:0] adder_product_fraction_in,
  output logic                              adder_product_ack_out,
  output logic                              response_valid_out,
  input  logic                              response_ready_in,
  output logic [WORD_WIDTH_IN_BITS-1:0]     response_result_out,
  output logic [TAG_WIDTH_IN_BITS-1:0]      response_tag_out,
  output logic                              response_timeout_out
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  state_e                        state_q;
  logic                          ready_q;
  logic                          mode_q;
  logic                          prec_q;
  logic                          op_valid_q;
  fp_fields_t                    op0_q;
  fp_fields_t                    op1_q;
  logic [WD_W-1:0]               wd_q;
  logic                          product_ack_q;
  logic                          resp_valid_q;
  logic [WORD_WIDTH_IN_BITS-1:0] result_q;
  logic [TAG_WIDTH_IN_BITS-1:0]  tag_q;
  logic                          timeout_q;

  logic [WORD_W-1:0] op0_fields_w;
  logic [WORD_W-1:0] op1_fields_w;
  logic [WORD_W-1:0] product_word_w;

  float_point_pack_unpack #(.PACK(1'b0)) u_unpack_0 (
    .precision_i (request_precision_in),
    .data_i      (request_operand_0_in),
    .data_o      (op0_fields_w)
  );

  float_point_pack_unpack #(.PACK(1'b0)) u_unpack_1 (
    .precision_i (request_precision_in),
    .data_i      (request_operand_1_in),
    .data_o      (op1_fields_w)
  );

  float_point_pack_unpack #(.PACK(1'b1)) u_pack (
    .precision_i (prec_q),
    .data_i      ({adder_product_sign_in, adder_product_exponent_in, adder_product_fraction_in}),
    .data_o      (product_word_w)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  // NOTE: reset clears every register, including request_ready_out; ready rises on the first edge in IDLE.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q       <= ST_IDLE;
      ready_q       <= 1'b0;
      mode_q        <= 1'b0;
      prec_q        <= 1'b0;
      op_valid_q    <= 1'b0;
      op0_q         <= '0;
      op1_q         <= '0;
      wd_q          <= '0;
      product_ack_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      result_q      <= '0;
      tag_q         <= '0;
      timeout_q     <= 1'b0;
    end else begin
      product_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && request_valid_in) begin
            ready_q    <= 1'b0;
            mode_q     <= request_mode_in;
            prec_q     <= request_precision_in;
            tag_q      <= request_tag_in;
            op0_q      <= fp_fields_t'(op0_fields_w);
            op1_q      <= fp_fields_t'(op1_fields_w);
            op_valid_q <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (adder_issue_ack_in) begin
            op_valid_q <= 1'b0;
            wd_q       <= '0;
            state_q    <= ST_WAIT_RESULT;
          end
        end
        ST_WAIT_RESULT: begin
          // A product on the final watchdog cycle wins over the timeout.
          if (adder_product_valid_in) begin
            result_q      <= product_word_w;
            timeout_q     <= 1'b0;
            product_ack_q <= 1'b1;
            resp_valid_q  <= 1'b1;
            state_q       <= ST_RESPOND;
          end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            result_q     <= '0;
            timeout_q    <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESPOND;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ST_RESPOND: begin
          if (response_ready_in) begin
            resp_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign request_ready_out            = ready_q;
  assign adder_operantion_mode_out    = mode_q;
  assign adder_precision_out          = prec_q;
  assign adder_operand_0_valid_out    = op_valid_q;
  assign adder_operand_1_valid_out    = op_valid_q;
  assign adder_operand_0_sign_out     = op0_q.sign;
  assign adder_operand_0_exponent_out = op0_q.exponent;
  assign adder_operand_0_fraction_out = op0_q.fraction;
  assign adder_operand_1_sign_out     = op1_q.sign;
  assign adder_operand_1_exponent_out = op1_q.exponent;
  assign adder_operand_1_fraction_out = op1_q.fraction;
  assign adder_product_ack_out        = product_ack_q;
  assign response_valid_out           = resp_valid_q;
  assign response_result_out          = result_q;
  assign response_tag_out             = tag_q;
  assign response_timeout_out         = timeout_q;

endmodule
